keypad_scan: RTL and testbench

- Input-side counterpart of the multiplexed display scan: scans a 4x4 active-low key matrix and debounces it into a single key code.
- Drives one column low at a time and samples the row lines.
- Reports a confirmed press as a 4-bit code with a one-cycle valid strobe; the code feeds the time-setting logic.
- Sits beside the display scanner in the clock top, clocked from the board clock.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_scan_if.sv | 11 +
 rtl/kp_sync.sv | 23 ++
 rtl/keypad_scan.sv | 177 +++++++++++++++++
 tb/tb_keypad_scan.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_t;

  localparam logic [3:0] COL0_PAT = 4'b1110;
  localparam logic [3:0] COL1_PAT = 4'b1101;
  localparam logic [3:0] COL2_PAT = 4'b1011;
  localparam logic [3:0] COL3_PAT = 4'b0111;

  // One-cold column strobe for a given column index.
  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    col_pattern = COL0_PAT;
      2'd1:    col_pattern = COL1_PAT;
      2'd2:    col_pattern = COL2_PAT;
      default: col_pattern = COL3_PAT;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the decoded key outputs.
interface keypad_scan_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (output col, output key_code, output key_valid, output key_down, input row);
  modport slave  (input col, input key_code, input key_valid, input key_down, output row);
endinterface

// File: rtl/kp_sync.sv
// Two-flop synchronizer for the asynchronous row returns; idles at all-ones (no key).
module kp_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  logic [3:0] s1_q;
  logic [3:0] s2_q;

  // Two back-to-back flops to resolve metastability on the row lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 4'b1111;
      s2_q <= 4'b1111;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: column strobe, per-scan hit matrix,
// ghost-rejecting result decoder and press/release debounce FSM.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4096,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_C    = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [3:0] row_s;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [15:0]   hits_q, hits_d;
  logic          last_q, last_d;

  logic          res_vld_q, res_vld_d;
  res_kind_t     res_kind_q, res_kind_d;
  logic [3:0]    res_key_q, res_key_d;

  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;

  // Saturating increment for the match counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  kp_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.row),
    .q_o (row_s)
  );

  // Dwell counter, column rotation and capture of the rows seen in each column.
  always_comb begin
    logic [3:0] bit_idx;
    div_d     = div_q + 1'b1;
    col_idx_d = col_idx_q;
    hits_d    = hits_q;
    last_d    = 1'b0;
    bit_idx   = 4'd0;
    if (div_q == DIV_LAST) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
      last_d    = (col_idx_q == 2'd3);
      for (int r = 0; r < 4; r++) begin
        bit_idx         = {2'(r), col_idx_q};
        hits_d[bit_idx] = ~row_s[r];
      end
    end
  end

  // Classify the completed scan matrix; hits_q bit index is already row*4+col.
  always_comb begin
    int ones;
    ones       = $countones(hits_q);
    res_vld_d  = last_q;
    res_key_d  = 4'd0;
    res_kind_d = RES_MULTI;
    for (int k = 0; k < 16; k++) begin
      if (hits_q[k]) res_key_d = 4'(k);
    end
    if (ones == 0)      res_kind_d = RES_NONE;
    else if (ones == 1) res_kind_d = RES_SINGLE;
  end

  // Debounce FSM: stepped once per scan result.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    cnt_inc     = sat_inc(cnt_q);
    if (res_vld_q) begin
      case (state_q)
        ST_IDLE: begin
          if (res_kind_q == RES_SINGLE) begin
            state_d = ST_PRESS_CHK;
            cand_d  = res_key_q;
            cnt_d   = CNT_ONE;
          end
        end
        ST_PRESS_CHK: begin
          if (res_kind_q == RES_SINGLE && res_key_q == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_C) begin
              state_d     = ST_HELD;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
            end
          end else if (res_kind_q == RES_SINGLE) begin
            cand_d = res_key_q;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          // No rollover: any key activity keeps the current key held.
          if (res_kind_q == RES_NONE) begin
            state_d = ST_RELEASE_CHK;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          if (res_kind_q == RES_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_C) begin
              state_d    = ST_IDLE;
              key_down_d = 1'b0;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
      endcase
    end
  end

  // All state registers; everything returns to the idle scan on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      hits_q      <= '0;
      last_q      <= 1'b0;
      res_vld_q   <= 1'b0;
      res_kind_q  <= RES_NONE;
      res_key_q   <= 4'd0;
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      hits_q      <= hits_d;
      last_q      <= last_d;
      res_vld_q   <= res_vld_d;
      res_kind_q  <= res_kind_d;
      res_key_q   <= res_key_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign kp.col       = col_pattern(col_idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scans).
module tb_keypad_scan;
  logic        clk;
  logic        rst;
  logic [15:0] keys;   // pressed keys, bit index = row*4 + col

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;      // key_valid cycles seen
  int down_hi = 0;     // cycles with key_down high
  int down_lo = 0;     // cycles with key_down low

  keypad_scan_if kp();

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix model: a row reads low when a pressed key sits in a driven column.
  always_comb begin
    kp.row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
  end

  // Output activity counters sampled away from the active edge.
  always @(negedge clk) begin
    if (kp.key_valid) pulses <= pulses + 1;
    if (kp.key_down)  down_hi <= down_hi + 1;
    else              down_lo <= down_lo + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_scans(input int n);
    repeat (16 * n) @(negedge clk);
    #1;
  endtask

  initial begin
    int p0;
    int d0;
    logic [3:0] exp_col;
    rst  = 1'b0;
    keys = 16'h0000;
    #1 rst = 1'b1;
    #1;
    chk("rst_col", 32'(kp.col), 32'(4'b1110));
    chk("rst_code", 32'(kp.key_code), 0);
    chk("rst_valid", 32'(kp.key_valid), 0);
    chk("rst_down", 32'(kp.key_down), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Column rotation: four cycles per column, one bit low.
    for (int n = 0; n < 32; n++) begin
      #1;
      exp_col = 4'b1111 & ~(4'b0001 << ((n / 4) % 4));
      chk("col_rot", 32'(kp.col), 32'(exp_col));
      @(negedge clk);
    end
    #1;

    // Clean press of key 6 (row 1, col 2).
    p0 = pulses;
    keys = 16'h0040;
    wait_scans(4);
    chk("press_pulse", 32'(pulses - p0), 1);
    chk("press_code", 32'(kp.key_code), 6);
    chk("press_down", 32'(kp.key_down), 1);
    p0 = pulses;
    wait_scans(3);
    chk("press_no_repeat", 32'(pulses - p0), 0);
    chk("press_still_down", 32'(kp.key_down), 1);
    keys = 16'h0000;
    wait_scans(4);
    chk("release_down", 32'(kp.key_down), 0);
    chk("release_code_kept", 32'(kp.key_code), 6);

    // Bounce: key present on alternate scans.
    p0 = pulses;
    d0 = down_hi;
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      wait_scans(1);
    end
    wait_scans(1);
    chk("bounce_pulse", 32'(pulses - p0), 0);
    chk("bounce_down", 32'(down_hi - d0), 0);
    p0 = pulses;
    keys = 16'h0040;
    wait_scans(4);
    chk("bounce_then_pulse", 32'(pulses - p0), 1);
    chk("bounce_then_code", 32'(kp.key_code), 6);
    keys = 16'h0000;
    wait_scans(4);
    chk("bounce_release", 32'(kp.key_down), 0);

    // Ghost: rows 0 and 3 in column 1 from idle.
    p0 = pulses;
    d0 = down_hi;
    keys = 16'h2002;
    wait_scans(4);
    chk("ghost_pulse", 32'(pulses - p0), 0);
    chk("ghost_down", 32'(down_hi - d0), 0);
    chk("ghost_code", 32'(kp.key_code), 6);
    keys = 16'h0000;
    wait_scans(2);

    // Key 5 held, then key 9 added.
    p0 = pulses;
    keys = 16'h0020;
    wait_scans(4);
    chk("k5_pulse", 32'(pulses - p0), 1);
    chk("k5_code", 32'(kp.key_code), 5);
    p0 = pulses;
    keys = 16'h0220;
    wait_scans(4);
    chk("k5_k9_pulse", 32'(pulses - p0), 0);
    chk("k5_k9_code", 32'(kp.key_code), 5);
    chk("k5_k9_down", 32'(kp.key_down), 1);

    // Short release (2 scans) then re-press: stays held, no re-report.
    keys = 16'h0020;
    wait_scans(1);
    p0 = pulses;
    d0 = down_lo;
    keys = 16'h0000;
    wait_scans(2);
    keys = 16'h0020;
    wait_scans(2);
    chk("short_rel_down", 32'(down_lo - d0), 0);
    chk("short_rel_pulse", 32'(pulses - p0), 0);

    // Full release.
    keys = 16'h0000;
    wait_scans(4);
    chk("full_rel_down", 32'(kp.key_down), 0);
    chk("full_rel_code", 32'(kp.key_code), 5);

    // Key 10 held, then asynchronous reset between clock edges.
    p0 = pulses;
    keys = 16'h0400;
    wait_scans(4);
    chk("k10_pulse", 32'(pulses - p0), 1);
    chk("k10_code", 32'(kp.key_code), 10);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_col", 32'(kp.col), 32'(4'b1110));
    chk("async_rst_code", 32'(kp.key_code), 0);
    chk("async_rst_valid", 32'(kp.key_valid), 0);
    chk("async_rst_down", 32'(kp.key_down), 0);
    @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    #1;
    wait_scans(4);
    chk("post_rst_pulse", 32'(pulses - p0), 1);
    chk("post_rst_code", 32'(kp.key_code), 10);
    chk("post_rst_down", 32'(kp.key_down), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
